// File: rtl/shift_seq_pkg.sv
// Shared constants for the shift sequencer: widths, op codes, FSM states,
// plus a helper that finds the next set count bit below a stage limit.
package shift_seq_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Returns {found, index} of the highest set bit of cnt strictly below lim.
    function automatic logic [2:0] hi_bit_below(
        input logic [CNT_W-1:0] cnt,
        input logic [2:0]       lim
    );
        logic [2:0] r;
        r = 3'b000;
        for (int i = 0; i < CNT_W; i++) begin
            if ((3'(i) < lim) && cnt[i]) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational single stage: shift/rotate data_i by 2^k_i per op_i when en_i.
// Ports: data_i, op_i, k_i, en_i in; data_o out.
module shift_stage
    import shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        op_i,
    input  logic [1:0]        k_i,
    input  logic              en_i,
    output logic [DATA_W-1:0] data_o
);

    logic [4:0]          sh;
    logic [2*DATA_W-1:0] dd;
    logic [2*DATA_W-1:0] rot_l;
    logic [2*DATA_W-1:0] rot_r;
    logic [DATA_W-1:0]   res;

    always_comb begin
        sh    = 5'd1 << k_i;
        dd    = {data_i, data_i};
        // Rotates fall out of shifting the doubled word.
        rot_l = dd << sh;
        rot_r = dd >> sh;
        res   = data_i;
        unique case (op_i)
            OP_ROL:  res = rot_l[2*DATA_W-1:DATA_W];
            OP_SLL:  res = data_i << sh;
            OP_ROR:  res = rot_r[DATA_W-1:0];
            OP_SRL:  res = data_i >> sh;
            default: res = data_i;
        endcase
        data_o = en_i ? res : data_i;
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one 2^k stage per RUN cycle, valid/ready I/O.
// Ports: clk, rst, in_valid/in_ready/in_data/in_cnt/in_op, out_valid/out_ready/out_data, busy. Macro: ZERO_SKIP_EN.
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        k_q, k_d;
    logic [DATA_W-1:0] stage_out;
`ifdef ZERO_SKIP_EN
    logic [2:0]        nb;
`endif

    shift_stage u_stage (
        .data_i (acc_q),
        .op_i   (op_q),
        .k_i    (k_q),
        .en_i   (cnt_q[k_q]),
        .data_o (stage_out)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        k_d     = k_q;
`ifdef ZERO_SKIP_EN
        nb      = 3'b000;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    acc_d = in_data;
                    cnt_d = in_cnt;
                    op_d  = in_op;
`ifdef ZERO_SKIP_EN
                    nb = hi_bit_below(in_cnt, 3'd4);
                    if (nb[2]) begin
                        k_d     = nb[1:0];
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    k_d     = 2'd3;
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
                acc_d = stage_out;
`ifdef ZERO_SKIP_EN
                nb = hi_bit_below(cnt_q, {1'b0, k_q});
                if (nb[2]) begin
                    k_d = nb[1:0];
                end else begin
                    state_d = ST_DONE;
                end
`else
                if (k_q == 2'd0) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q - 2'd1;
                end
`endif
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_ROL;
            k_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            k_q     <= k_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: latency, results, hold, reset abort,
// back-to-back streaming. Honors ZERO_SKIP_EN for latency expectations.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    shift_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] c);
`ifdef ZERO_SKIP_EN
        return (c == 4'd0) ? 1 : $countones(c) + 1;
`else
        return 5;
`endif
    endfunction

    // Bit-serial reference: one single-bit step per count unit.
    function automatic logic [15:0] model(input logic [15:0] d,
                                          input logic [3:0] c,
                                          input logic [1:0] op);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(c)) begin
                case (op)
                    2'b00: r = {r[14:0], r[15]};
                    2'b01: r = {r[14:0], 1'b0};
                    2'b10: r = {r[0], r[15:1]};
                    default: r = {1'b0, r[15:1]};
                endcase
            end
        end
        return r;
    endfunction

    // Counts cycles after acceptance until out_valid, bounded.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk1("timeout", out_valid, 1'b1);
    endtask

    task automatic do_op(input string tag, input logic [15:0] d,
                         input logic [3:0] c, input logic [1:0] op,
                         input logic [15:0] exp);
        int n;
        chk1({tag, "_rdy"}, in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = d;
        in_cnt   = c;
        in_op    = op;
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        in_cnt   = ~c;
        in_op    = ~op;
        chk1({tag, "_busy"}, busy, 1'b1);
        wait_out(n);
        chkn({tag, "_lat"}, n, exp_lat(c));
        chk16({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1({tag, "_idle"}, in_ready, 1'b1);
        chk1({tag, "_ovl"}, out_valid, 1'b0);
    endtask

    logic [15:0] bd [4];
    logic [3:0]  bc [4];
    logic [1:0]  bo [4];

    initial begin
        int n;
        int prev;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_cnt    = 4'h0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk1("rst_ready", in_ready, 1'b1);
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk16("rst_data", out_data, 16'h0000);

        do_op("ror1", 16'h8001, 4'd1, 2'b10, 16'hC000);
        do_op("rol4", 16'h1234, 4'd4, 2'b00, 16'h2341);
        do_op("sll4", 16'h1234, 4'd4, 2'b01, 16'h2340);
        do_op("srl15", 16'h8000, 4'd15, 2'b11, 16'h0001);
        do_op("z_rol", 16'hA5A5, 4'd0, 2'b00, 16'hA5A5);
        do_op("z_sll", 16'hA5A5, 4'd0, 2'b01, 16'hA5A5);
        do_op("z_ror", 16'hA5A5, 4'd0, 2'b10, 16'hA5A5);
        do_op("z_srl", 16'hA5A5, 4'd0, 2'b11, 16'hA5A5);
        do_op("ror10", 16'h1234, 4'd10, 2'b10, 16'h8D04);
        do_op("sll15", 16'hFFFF, 4'd15, 2'b01, 16'h8000);

        // Hold in DONE with stalled consumer; in_valid pulses ignored.
        in_valid = 1'b1;
        in_data  = 16'h00FF;
        in_cnt   = 4'd8;
        in_op    = 2'b01;
        tick();
        in_valid = 1'b0;
        wait_out(n);
        chk16("hold_d0", out_data, 16'hFF00);
        for (int i = 0; i < 3; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_data  = 16'h1111;
            in_cnt   = 4'd3;
            tick();
            chk1("hold_v", out_valid, 1'b1);
            chk1("hold_rdy", in_ready, 1'b0);
            chk16("hold_d", out_data, 16'hFF00);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("hold_rel", in_ready, 1'b1);
        do_op("after_hold", 16'h0001, 4'd1, 2'b00, 16'h0002);

        // Reset in the second RUN cycle, with in_valid/out_ready also high.
        in_valid = 1'b1;
        in_data  = 16'hF00F;
        in_cnt   = 4'd5;
        in_op    = 2'b00;
        tick();
        in_valid = 1'b0;
        tick();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk1("abort_rdy", in_ready, 1'b1);
        chk1("abort_valid", out_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk16("abort_data", out_data, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk1("abort_quiet", out_valid, 1'b0);
        end
        do_op("post_rst", 16'h0001, 4'd15, 2'b00, 16'h8000);

        // Streaming with in_valid and out_ready tied high.
        bd[0] = 16'hBEEF; bc[0] = 4'd3;  bo[0] = 2'b00;
        bd[1] = 16'h0F0F; bc[1] = 4'd12; bo[1] = 2'b11;
        bd[2] = 16'h8421; bc[2] = 4'd7;  bo[2] = 2'b10;
        bd[3] = 16'h00C3; bc[3] = 4'd9;  bo[3] = 2'b01;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = bd[0];
        in_cnt    = bc[0];
        in_op     = bo[0];
        prev      = cyc - 1;
        for (int i = 0; i < 4; i++) begin
            chk1("b2b_rdy", in_ready, 1'b1);
            tick();
            in_data = 16'h5A5A ^ 16'(i);
            in_cnt  = 4'(15 - i);
            in_op   = 2'(i + 1);
            wait_out(n);
            chk16("b2b_data", out_data, model(bd[i], bc[i], bo[i]));
            if (i > 0) begin
                chkn("b2b_gap", cyc - prev, exp_lat(bc[i]) + 1);
            end
            prev = cyc;
            if (i < 3) begin
                in_data = bd[i+1];
                in_cnt  = bc[i+1];
                in_op   = bo[i+1];
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
